// File: rtl/vga_framebuffer_reader.sv
// VGA 640x480@60 scan-out of a 160x120 RGB332 frame buffer, 4x4 pixel replication.
// Pipeline: counters -> read request -> buffer data -> registered colour/sync.
module vga_framebuffer_reader #(
    parameter logic [14:0] FB_BASE  = 15'h0000,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        pclk,
    input  logic        rst_n,
    output logic [14:0] rd_addr,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0] ROW_STEP = 15'd160;

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [14:0] r_row_base;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_vis2;
    logic        r_hs2;
    logic        r_vs2;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_visible;
    logic w_hs_raw;
    logic w_vs_raw;

    assign w_h_wrap  = (r_h_cnt == H_LAST);
    assign w_v_wrap  = (r_v_cnt == V_LAST);
    assign w_visible = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_raw  = !((r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
    assign w_vs_raw  = !((r_v_cnt >= V_SS) && (r_v_cnt < V_SE));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_row_base <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
                // each buffer row covers four display lines
                if (w_v_wrap)
                    r_row_base <= '0;
                else if (r_v_cnt[1:0] == 2'b11)
                    r_row_base <= r_row_base + ROW_STEP;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr     <= FB_BASE;
            rd_en       <= 1'b0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            rd_addr     <= w_visible ?
                           FB_BASE + r_row_base + {7'd0, r_h_cnt[9:2]} :
                           FB_BASE;
            rd_en       <= w_visible;
            r_hs1       <= w_hs_raw;
            r_vs1       <= w_vs_raw;
            frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vis2 <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            r_vis2 <= rd_en;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            vga_hs <= r_hs2;
            vga_vs <= r_vs2;
            // widen 3/3/2-bit fields by repeating their MSBs
            vga_r  <= r_vis2 ? {rd_data[7:5], rd_data[7]} : 4'd0;
            vga_g  <= r_vis2 ? {rd_data[4:2], rd_data[4]} : 4'd0;
            vga_b  <= r_vis2 ? {rd_data[1:0], rd_data[1:0]} : 4'd0;
        end
    end

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench for vga_framebuffer_reader: reference timing model feeding a scoreboard,
// plus directed checks of sync edges, addressing, colour and mid-frame reset.
module tb_vga_framebuffer_reader;

    localparam logic [14:0] BASE = 15'h4000;
    localparam int VA  = 16;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 4;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int HT  = 800;
    localparam int FRM = HT * VT;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data = 8'd0;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    logic [7:0] mem [0:32767];

    int n_chk = 0;
    int n_fail = 0;
    int e = 0;
    int m_h = 0;
    int m_v = 0;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } out_t;

    typedef struct packed {
        logic [14:0] addr;
        logic        en;
        logic        fs;
    } rd_t;

    out_t q_out[$];
    rd_t  q_rd[$];

    vga_framebuffer_reader #(
        .FB_BASE (BASE),
        .H_ACTIVE(640),
        .H_FP    (16),
        .H_SYNC  (96),
        .H_BP    (48),
        .V_ACTIVE(VA),
        .V_FP    (VFP),
        .V_SYNC  (VSY),
        .V_BP    (VBP)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .frame_start(frame_start)
    );

    always #20 pclk = ~pclk;

    // synchronous buffer: data one cycle after address
    always @(posedge pclk) rd_data <= mem[rd_addr];

    function automatic logic vis(int h, int v);
        return (h < 640) && (v < VA);
    endfunction

    function automatic logic [14:0] exp_addr(int h, int v);
        if (vis(h, v))
            return 15'(int'(BASE) + (v / 4) * 160 + h / 4);
        return BASE;
    endfunction

    function automatic rd_t exp_rd(int h, int v);
        rd_t t;
        t.addr = exp_addr(h, v);
        t.en   = vis(h, v);
        t.fs   = (h == 0) && (v == 0);
        return t;
    endfunction

    function automatic out_t exp_out(int h, int v);
        out_t t;
        logic [7:0] d;
        d    = mem[exp_addr(h, v)];
        t.hs = !((h >= 656) && (h < 752));
        t.vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        t.r  = vis(h, v) ? {d[7:5], d[7]} : 4'd0;
        t.g  = vis(h, v) ? {d[4:2], d[4]} : 4'd0;
        t.b  = vis(h, v) ? {d[1:0], d[1:0]} : 4'd0;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        out_t eo;
        rd_t  er;
        q_out.push_back(exp_out(m_h, m_v));
        q_rd.push_back(exp_rd(m_h, m_v));
        eo = q_out.pop_front();
        er = q_rd.pop_front();
        n_chk++;
        assert ({vga_hs, vga_vs, vga_r, vga_g, vga_b} === eo) else begin
            n_fail++;
            $error("FAIL sb_out e=%0d observed=%h expected=%h", e,
                   {vga_hs, vga_vs, vga_r, vga_g, vga_b}, eo);
        end
        n_chk++;
        assert ({rd_addr, rd_en, frame_start} === er) else begin
            n_fail++;
            $error("FAIL sb_rd e=%0d observed=%h expected=%h", e,
                   {rd_addr, rd_en, frame_start}, er);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        e++;
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        @(negedge pclk);
        sb_check();
    endtask

    task automatic run_until(input int t);
        while (e < t) tick();
    endtask

    task automatic start();
        q_out.delete();
        q_rd.delete();
        repeat (3) q_out.push_back('{1'b1, 1'b1, 4'd0, 4'd0, 4'd0});
        q_rd.push_back('{BASE, 1'b0, 1'b0});
        e = 0;
        m_h = 0;
        m_v = 0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++)
            mem[i] = 8'((i * 37) ^ (i >> 5));
        mem[BASE]     = 8'hE3;
        mem[BASE + 1] = 8'b101_010_01;

        repeat (3) @(negedge pclk);
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_vs", 32'(vga_vs), 32'd1);
        chk("rst_addr", 32'(rd_addr), 32'(BASE));
        rst_n = 1'b1;
        start();
        sb_check();
        chk("fs_e0", 32'(frame_start), 32'd0);
        chk("col_e0", 32'({vga_r, vga_g, vga_b}), 32'd0);

        run_until(1);
        chk("fs_e1", 32'(frame_start), 32'd1);
        chk("en_e1", 32'(rd_en), 32'd1);
        run_until(2);
        chk("fs_e2", 32'(frame_start), 32'd0);
        run_until(4);
        chk("addr_3_0", 32'(rd_addr), 32'(BASE));
        chk("col_E3", 32'({vga_r, vga_g, vga_b}), 32'hF0F);
        run_until(5);
        chk("addr_4_0", 32'(rd_addr), 32'(BASE + 15'd1));
        run_until(7);
        chk("col_A9", 32'({vga_r, vga_g, vga_b}), 32'hB45);
        run_until(641);
        chk("en_blank", 32'(rd_en), 32'd0);
        chk("addr_blank", 32'(rd_addr), 32'(BASE));
        run_until(643);
        chk("col_blank", 32'({vga_r, vga_g, vga_b}), 32'd0);
        run_until(658);
        chk("hs_pre", 32'(vga_hs), 32'd1);
        run_until(659);
        chk("hs_fall", 32'(vga_hs), 32'd0);
        run_until(754);
        chk("hs_low_end", 32'(vga_hs), 32'd0);
        run_until(755);
        chk("hs_rise", 32'(vga_hs), 32'd1);
        run_until(HT + 659);
        chk("hs_period", 32'(vga_hs), 32'd0);
        run_until(3 * HT + 4);
        chk("addr_3_3", 32'(rd_addr), 32'(BASE));
        run_until(4 * HT + 1);
        chk("addr_0_4", 32'(rd_addr), 32'(BASE + 15'd160));
        run_until(15 * HT + 640);
        chk("addr_last", 32'(rd_addr), 32'(BASE + 15'd639));
        run_until((VA + VFP) * HT + 2);
        chk("vs_pre", 32'(vga_vs), 32'd1);
        run_until((VA + VFP) * HT + 3);
        chk("vs_fall", 32'(vga_vs), 32'd0);
        run_until((VA + VFP) * HT + 1602);
        chk("vs_low_end", 32'(vga_vs), 32'd0);
        run_until((VA + VFP) * HT + 1603);
        chk("vs_rise", 32'(vga_vs), 32'd1);
        run_until(FRM + 1);
        chk("fs_frame2", 32'(frame_start), 32'd1);
        chk("addr_frame2", 32'(rd_addr), 32'(BASE));
        run_until(FRM + 4 * HT + 1);
        chk("addr_f2_0_4", 32'(rd_addr), 32'(BASE + 15'd160));

        run_until(FRM + 5 * HT + 300);
        #5 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(rd_en), 32'd0);
        chk("mid_rst_addr", 32'(rd_addr), 32'(BASE));
        chk("mid_rst_col", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("mid_rst_hs", 32'(vga_hs), 32'd1);
        chk("mid_rst_fs", 32'(frame_start), 32'd0);
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        start();
        sb_check();
        run_until(1);
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        run_until(659);
        chk("post_rst_hs", 32'(vga_hs), 32'd0);
        run_until(FRM + 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
